// File: rtl/msx_slot_bus_master.sv
// MSX slot bus initiator: runs single Z80-timed memory read/write cycles on the cartridge slot.
// Define MSX_SLOT_BUS_MASTER_WAIT_EN to honour /WAIT (TW states plus timeout); otherwise /WAIT is ignored.
module msx_slot_bus_master #(
  parameter int T_CLKS     = 6,
  parameter int WAIT_LIMIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        req_wr,
  input  logic [15:0] req_a,
  input  logic [7:0]  req_wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        timeout,
  output logic [15:0] slot_a,
  inout  wire  [7:0]  slot_d,
  output logic        slot_nmerq,
  output logic        slot_nsltsl,
  output logic        slot_nrd,
  output logic        slot_nwr,
  input  logic        slot_nwait
);

  localparam int PW = $clog2(T_CLKS);
  localparam logic [PW-1:0] HALF = PW'(T_CLKS / 2);
  localparam logic [PW-1:0] LAST = PW'(T_CLKS - 1);
  localparam logic [7:0] WL = WAIT_LIMIT[7:0];

`ifdef MSX_SLOT_BUS_MASTER_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {ST_IDLE, ST_T1, ST_T2, ST_TW, ST_T3} state_t;

  state_t        state_reg, state_next;
  logic [PW-1:0] ph_reg, ph_next;
  logic          wr_reg, wr_next;
  logic [7:0]    wdata_reg, wdata_next;
  logic [7:0]    tw_reg, tw_next;
  logic          to_reg, to_next;
  logic [7:0]    rhold_reg, rhold_next;
  logic          pend_reg, pend_next;
  logic          d_oe_reg, d_oe_next;
  logic          nwait_s1_reg, nwait_s2_reg;
  logic          busy_next, done_next, timeout_next;
  logic [7:0]    rdata_next;
  logic [15:0]   slot_a_next;
  logic          nmerq_next, nrd_next, nwr_next;
  logic          ph_last, wait_low, mem_active, wr_active;

  assign slot_d   = d_oe_reg ? wdata_reg : 8'hzz;
  assign ph_last  = (ph_reg == LAST);
  assign wait_low = WAIT_EN && !nwait_s2_reg;

  always_comb begin
    state_next   = state_reg;
    ph_next      = ph_reg;
    wr_next      = wr_reg;
    wdata_next   = wdata_reg;
    tw_next      = tw_reg;
    to_next      = to_reg;
    rhold_next   = rhold_reg;
    pend_next    = 1'b0;
    busy_next    = busy;
    done_next    = 1'b0;
    timeout_next = 1'b0;
    rdata_next   = rdata;
    slot_a_next  = slot_a;

    if (state_reg != ST_IDLE)
      ph_next = ph_last ? '0 : ph_reg + 1'b1;

    case (state_reg)
      ST_IDLE: begin
        // pend_reg marks the cycle after T3: results are published here
        busy_next    = 1'b0;
        done_next    = pend_reg;
        timeout_next = WAIT_EN && pend_reg && to_reg;
        if (pend_reg)
          rdata_next = rhold_reg;
        if (req) begin
          state_next  = ST_T1;
          ph_next     = '0;
          wr_next     = req_wr;
          wdata_next  = req_wdata;
          slot_a_next = req_a;
          tw_next     = 8'd0;
          to_next     = 1'b0;
          busy_next   = 1'b1;
        end
      end
      ST_T1: begin
        if (ph_last)
          state_next = ST_T2;
      end
      ST_T2, ST_TW: begin
        if (ph_last) begin
          if (!wait_low) begin
            state_next = ST_T3;
          end else if (tw_reg == WL) begin
            state_next = ST_T3;
            to_next    = 1'b1;
          end else begin
            state_next = ST_TW;
            tw_next    = tw_reg + 8'd1;
          end
        end
      end
      ST_T3: begin
        // sampled on the edge that also raises /RD, so the responder is still driving
        if (ph_next == HALF && !wr_reg)
          rhold_next = to_reg ? 8'hFF : slot_d;
        if (ph_last) begin
          state_next = ST_IDLE;
          pend_next  = 1'b1;
          busy_next  = 1'b0;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    mem_active = (state_next == ST_T1 && ph_next >= HALF) || state_next == ST_T2 ||
                 state_next == ST_TW || (state_next == ST_T3 && ph_next < HALF);
    wr_active  = (state_next == ST_T2 && ph_next >= HALF) || state_next == ST_TW ||
                 (state_next == ST_T3 && ph_next < HALF);
    nmerq_next = !mem_active;
    nrd_next   = !(mem_active && !wr_next);
    nwr_next   = !(wr_active && wr_next);
    d_oe_next  = wr_next && ((state_next == ST_T1 && ph_next >= HALF) || state_next == ST_T2 ||
                             state_next == ST_TW || state_next == ST_T3);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      ph_reg       <= '0;
      wr_reg       <= 1'b0;
      wdata_reg    <= 8'd0;
      tw_reg       <= 8'd0;
      to_reg       <= 1'b0;
      rhold_reg    <= 8'd0;
      pend_reg     <= 1'b0;
      d_oe_reg     <= 1'b0;
      nwait_s1_reg <= 1'b1;
      nwait_s2_reg <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      timeout      <= 1'b0;
      rdata        <= 8'd0;
      slot_a       <= 16'd0;
      slot_nmerq   <= 1'b1;
      slot_nsltsl  <= 1'b1;
      slot_nrd     <= 1'b1;
      slot_nwr     <= 1'b1;
    end else begin
      state_reg    <= state_next;
      ph_reg       <= ph_next;
      wr_reg       <= wr_next;
      wdata_reg    <= wdata_next;
      tw_reg       <= tw_next;
      to_reg       <= to_next;
      rhold_reg    <= rhold_next;
      pend_reg     <= pend_next;
      d_oe_reg     <= d_oe_next;
      nwait_s1_reg <= slot_nwait;
      nwait_s2_reg <= nwait_s1_reg;
      busy         <= busy_next;
      done         <= done_next;
      timeout      <= timeout_next;
      rdata        <= rdata_next;
      slot_a       <= slot_a_next;
      slot_nmerq   <= nmerq_next;
      slot_nsltsl  <= nmerq_next;
      slot_nrd     <= nrd_next;
      slot_nwr     <= nwr_next;
    end
  end

endmodule

// File: tb/tb_msx_slot_bus_master.sv
// Bench for msx_slot_bus_master: randomized reads/writes against a slot memory responder,
// with a scoreboard checking latency, data, timeout and strobe behaviour per completed cycle.
module tb_msx_slot_bus_master;

  localparam int T    = 6;
  localparam int HALF = T / 2;
  localparam int WL   = 3;
`ifdef MSX_SLOT_BUS_MASTER_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        req_wr;
  logic [15:0] req_a;
  logic [7:0]  req_wdata;
  logic        busy, done, timeout;
  logic [7:0]  rdata;
  logic [15:0] slot_a;
  wire  [7:0]  slot_d;
  logic        slot_nmerq, slot_nsltsl, slot_nrd, slot_nwr;
  logic        slot_nwait;

  msx_slot_bus_master #(.T_CLKS(T), .WAIT_LIMIT(WL)) dut (
    .clk(clk), .reset(reset), .req(req), .req_wr(req_wr), .req_a(req_a), .req_wdata(req_wdata),
    .busy(busy), .done(done), .rdata(rdata), .timeout(timeout), .slot_a(slot_a), .slot_d(slot_d),
    .slot_nmerq(slot_nmerq), .slot_nsltsl(slot_nsltsl), .slot_nrd(slot_nrd), .slot_nwr(slot_nwr),
    .slot_nwait(slot_nwait)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [7:0]  exp_rd;
    bit          exp_to;
    int          lat;
    int          acc;
  } item_t;

  item_t      sb_q[$];
  int         k_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  int         cyc    = 0;
  logic [7:0] rmem [0:65535];
  logic [7:0] mmem [0:65535];
  logic [7:0] model_last_rd = 8'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Slot memory responder: drives data while /RD is low, stores while /WR is low, and holds
  // /WAIT low for k*T+HALF clocks from /MERQ falling, which costs exactly k TW states.
  assign slot_d = slot_nrd ? 8'hzz : rmem[slot_a];

  logic        prev_meq = 1'b1, prev_nrd = 1'b1, prev_nwr = 1'b1;
  int          nrd_falls = 0, nwr_falls = 0, wcnt = 0;
  logic [15:0] cap_a = 16'd0;
  logic [7:0]  cap_d = 8'd0;

  always @(negedge clk) begin
    if (prev_meq && !slot_nmerq) begin
      nrd_falls = 0;
      nwr_falls = 0;
      cap_a     = slot_a;
      wcnt      = (k_q.size() > 0) ? k_q.pop_front() * T + HALF : HALF;
      slot_nwait = (wcnt == 0);
    end else if (wcnt > 0) begin
      wcnt--;
      if (wcnt == 0) slot_nwait = 1'b1;
    end
    if (prev_nrd && !slot_nrd) nrd_falls++;
    if (prev_nwr && !slot_nwr) nwr_falls++;
    if (!slot_nwr) begin
      rmem[slot_a] = slot_d;
      cap_d        = slot_d;
    end
    prev_meq = slot_nmerq;
    prev_nrd = slot_nrd;
    prev_nwr = slot_nwr;
  end

  // Monitor: one scoreboard pop per done pulse.
  item_t mon_it;
  always @(negedge clk) begin
    if (!reset && done) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 required no pending cycle (cycle %0d)", cyc);
      end else begin
        mon_it = sb_q.pop_front();
        $display("txn %s a=%04h d=%02h rdata=%02h timeout=%0d latency=%0d", mon_it.wr ? "WR" : "RD",
                 mon_it.a, mon_it.d, rdata, timeout, cyc - mon_it.acc);
        chk("latency", cyc - mon_it.acc, mon_it.lat);
        chk("timeout", {31'd0, timeout}, {31'd0, mon_it.exp_to});
        chk("rdata", {24'd0, rdata}, {24'd0, mon_it.exp_rd});
        chk("strobes_idle", {28'd0, slot_nmerq, slot_nsltsl, slot_nrd, slot_nwr}, 32'hF);
        chk("bus_addr", {16'd0, cap_a}, {16'd0, mon_it.a});
        chk("nrd_pulses", nrd_falls, mon_it.wr ? 0 : 1);
        chk("nwr_pulses", nwr_falls, mon_it.wr ? 1 : 0);
        if (mon_it.wr) chk("bus_wdata", {24'd0, cap_d}, {24'd0, mon_it.d});
      end
    end
  end

  // Issue one request; the expected response is computed from the slot rules and queued.
  task automatic issue(input bit wr, input logic [15:0] a, input logic [7:0] d, input int k,
                       input bit hold);
    item_t it;
    int    guard = 0;
    int    tw;
    @(negedge clk);
    req = 1'b1; req_wr = wr; req_a = a; req_wdata = d;
    while (busy && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    if (busy) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_wait: got busy=1 for %0d clks required acceptance", guard);
      req = 1'b0;
      return;
    end
    tw        = WAIT_EN ? ((k < WL) ? k : WL) : 0;
    it.wr     = wr;
    it.a      = a;
    it.d      = d;
    it.exp_to = WAIT_EN && (k > WL);
    it.lat    = 3 * T + 1 + T * tw;
    it.acc    = cyc + 1;
    if (wr) begin
      mmem[a] = d;
    end else begin
      model_last_rd = it.exp_to ? 8'hFF : mmem[a];
    end
    it.exp_rd = model_last_rd;
    sb_q.push_back(it);
    k_q.push_back(k);
    @(posedge clk);
    #1;
    if (!hold) req = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb_q.size() > 0 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() > 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d cycles outstanding required 0", sb_q.size());
    end
    sb_q.delete();
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] ia;
    for (int i = 0; i < 65536; i++) begin
      ia = 16'(i);
      rmem[i] = ia[7:0] ^ ia[15:8] ^ 8'h5A;
      mmem[i] = rmem[i];
    end
    rmem[16'h6001] = 8'hA5;
    mmem[16'h6001] = 8'hA5;

    reset = 1'b1; req = 1'b0; req_wr = 1'b0; req_a = 16'd0; req_wdata = 8'd0; slot_nwait = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_slot_a", {16'd0, slot_a}, 32'd0);
    chk("rst_strobes", {28'd0, slot_nmerq, slot_nsltsl, slot_nrd, slot_nwr}, 32'hF);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Directed: plain write, plain read, waited read, stuck-wait read, waited write.
    issue(1'b1, 16'h4000, 8'h64, 0, 1'b0);
    issue(1'b0, 16'h6001, 8'h00, 0, 1'b0);
    issue(1'b0, 16'h4000, 8'h00, 2, 1'b0);
    issue(1'b0, 16'h4003, 8'h00, 5, 1'b0);
    issue(1'b1, 16'h4004, 8'h9C, 3, 1'b0);
    drain();

    // Back-to-back alternating write/read to 0x5000 with req held high.
    for (int i = 0; i < 6; i++)
      issue((i % 2) == 0, 16'h5000, 8'($urandom), 0, i != 5);
    drain();

    // Randomized mix with occasional back-to-back and random wait lengths.
    for (int i = 0; i < 40; i++)
      issue(1'($urandom), 16'h4000 | 16'($urandom_range(0, 7)), 8'($urandom),
            int'($urandom_range(0, 5)), (i != 39) && ($urandom_range(0, 1) == 1));
    drain();

    // Reset in T2 ph2 of a write: bus released at once, no done, write never reaches memory.
    issue(1'b1, 16'h7FFF, 8'h3C, 0, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_strobes", {28'd0, slot_nmerq, slot_nsltsl, slot_nrd, slot_nwr}, 32'hF);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    sb_q.delete();
    k_q.delete();
    mmem[16'h7FFF] = rmem[16'h7FFF];
    model_last_rd  = 8'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_rdata", {24'd0, rdata}, 32'd0);
    issue(1'b0, 16'h7FFF, 8'h00, 0, 1'b0);
    issue(1'b1, 16'h7FFE, 8'hE7, 1, 1'b0);
    issue(1'b0, 16'h7FFE, 8'h00, 0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
